// File: rtl/demux_pkg.sv
// Shared constants and channel-index type for the 1-to-4 stream demultiplexer.
// No logic lives here. It only fixes the channel count and the select width.
// Every demux file imports this package.
package demux_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] ch_idx_t;
endpackage

// File: rtl/demux_slot.sv
// One-entry register slice holding a single beat for one output channel.
// Latency 1 cycle from load to vld. A load on the same edge as a drain keeps vld high with new data.
// Backpressure: dat holds while vld & ~drain_rdy; the owner gates load using vld/drain_rdy.
module demux_slot
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              drain_rdy,
    output logic              vld,
    output logic [DATA_W-1:0] dat
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            dat <= '0;
        end else if (load) begin
            vld <= 1'b1;
            dat <= load_data;
        end else if (vld && drain_rdy) begin
            // Payload is deliberately left in place after a drain.
            vld <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1_to_4_stream.sv
// Registered 1-to-4 valid/ready demux; DEMUX_AUTO_SEL_EN replaces in_sel with a round-robin pointer.
// Latency 1 cycle per beat, throughput 1 beat/cycle per channel.
// Backpressure: in_ready = target slot empty or draining this cycle (combinational).
module demux_1_to_4_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data
);

    ch_idx_t tgt;
    logic    accept;

`ifdef DEMUX_AUTO_SEL_EN
    ch_idx_t ptr;

    // Pointer advances only on accept, so a stalled channel is never skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= ptr + 1'b1;
        end
    end

    assign tgt = ptr;
`else
    assign tgt = in_sel;
`endif

    assign in_ready = ~out_valid[tgt] | out_ready[tgt];
    assign accept   = in_valid & in_ready;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(
            .DATA_W(DATA_W)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (accept && (tgt == ch_idx_t'(k))),
            .load_data(in_data),
            .drain_rdy(out_ready[k]),
            .vld      (out_valid[k]),
            .dat      (out_data[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_demux_1_to_4_stream.sv
// Directed self-checking bench for demux_1_to_4_stream.
// The default build checks in_sel routing; a DEMUX_AUTO_SEL_EN build checks the round-robin pointer.
module tb_demux_1_to_4_stream;
    localparam int DATA_W = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic [1:0]    in_sel;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [31:0]   out_data;

    int total = 0;
    int bad   = 0;

    demux_1_to_4_stream #(.DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1ns after each rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ch(input int k);
        return out_data[k*8 +: 8];
    endfunction

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_sel    = 2'd0;
        out_ready = 4'b0000;
        #12;
        chk("rst_out_valid", {28'd0, out_valid}, 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'h1);
        rst_n = 1'b1;
        tick;

`ifndef DEMUX_AUTO_SEL_EN
        // Single beat to channel 2
        in_sel = 2'd2; in_data = 8'hA5; in_valid = 1'b1;
        #1 chk("t1_in_ready", {31'd0, in_ready}, 32'h1);
        tick;
        in_valid = 1'b0;
        chk("t1_out_valid", {28'd0, out_valid}, 32'h4);
        chk("t1_ch2", {24'd0, ch(2)}, 32'hA5);

        // Backpressure on channel 1
        in_sel = 2'd1; in_data = 8'h5A; in_valid = 1'b1;
        tick;
        in_data = 8'h77;
        #1 chk("t2_in_ready_stall", {31'd0, in_ready}, 32'h0);
        tick;
        chk("t2_ch1_hold", {24'd0, ch(1)}, 32'h5A);
        chk("t2_valid_hold", {28'd0, out_valid}, 32'h6);
        out_ready = 4'b0010;
        #1 chk("t2_in_ready_drain", {31'd0, in_ready}, 32'h1);
        tick;
        in_valid = 1'b0; out_ready = 4'b0000;
        chk("t2_ch1_new", {24'd0, ch(1)}, 32'h77);
        chk("t2_valid_reload", {28'd0, out_valid}, 32'h6);
        out_ready = 4'b0110;
        tick;
        out_ready = 4'b0000;
        chk("t2_drained", {28'd0, out_valid}, 32'h0);
        chk("t2_data_kept", {24'd0, ch(2)}, 32'hA5);

        // Simultaneous drain and reload on channel 0
        in_sel = 2'd0; in_data = 8'h11; in_valid = 1'b1;
        tick;
        in_data = 8'h22; out_ready = 4'b0001;
        tick;
        in_valid = 1'b0; out_ready = 4'b0000;
        chk("t3_valid", {28'd0, out_valid}, 32'h1);
        chk("t3_ch0", {24'd0, ch(0)}, 32'h22);
        out_ready = 4'b1111;
        tick;
        chk("t3_drained", {28'd0, out_valid}, 32'h0);

        // Back-to-back across all channels with every consumer ready
        for (int i = 0; i < 4; i++) begin
            in_sel = 2'(i); in_data = 8'(i + 1); in_valid = 1'b1;
            #1 chk($sformatf("t4_in_ready%0d", i), {31'd0, in_ready}, 32'h1);
            tick;
            chk($sformatf("t4_valid%0d", i), {28'd0, out_valid}, 32'(1 << i));
            chk($sformatf("t4_data%0d", i), {24'd0, ch(i)}, 32'(i + 1));
        end
        in_valid = 1'b0;
        tick;
        chk("t4_empty", {28'd0, out_valid}, 32'h0);

        // Async reset with every slot full
        out_ready = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            in_sel = 2'(i); in_data = 8'(8'hC0 + i); in_valid = 1'b1;
            tick;
        end
        in_sel = 2'd0;
        chk("t5_full", {28'd0, out_valid}, 32'hF);
        #1 chk("t5_in_ready_full", {31'd0, in_ready}, 32'h0);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_async_valid", {28'd0, out_valid}, 32'h0);
        chk("t5_async_ready", {31'd0, in_ready}, 32'h1);
        chk("t5_async_data", out_data, 32'h0);
        in_valid = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
`else
        // Round-robin: in_sel held at 0 throughout, channel 2 never drains in round one
        in_sel = 2'd0; out_ready = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'(8'h10 + i); in_valid = 1'b1;
            tick;
            chk($sformatf("a_valid%0d", i), {28'd0, out_valid & ~4'b0100}, 32'(1 << (i % 4)) & 32'hB);
            chk($sformatf("a_data%0d", i), {24'd0, ch(i % 4)}, 32'(8'h10 + i));
        end
        chk("a_ch2_held", {28'd0, out_valid}, 32'h4 | 32'h1);
        // Pointer is now at 1; next beat goes to 1, then channel 2 stalls
        in_data = 8'h21;
        tick;
        chk("a_ch1", {24'd0, ch(1)}, 32'h21);
        in_data = 8'h22;
        for (int c = 0; c < 2; c++) begin
            #1 chk($sformatf("a_stall%0d", c), {31'd0, in_ready}, 32'h0);
            tick;
            chk($sformatf("a_stall_hold%0d", c), {24'd0, ch(2)}, 32'h12);
        end
        out_ready = 4'b1111;
        #1 chk("a_unstall", {31'd0, in_ready}, 32'h1);
        tick;
        chk("a_ch2_new", {24'd0, ch(2)}, 32'h22);
        in_data = 8'h23;
        tick;
        in_valid = 1'b0;
        chk("a_ch3", {24'd0, ch(3)}, 32'h23);
        chk("a_ch3_valid", {28'd0, out_valid}, 32'h8);
        tick;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
